// File: rtl/pipe_exe.sv
`default_nettype none
// ============================================================================
// Module   : pipe_exe
// Purpose  : Single-stage execute unit with valid/ready handshakes on both
//            sides. Most ALU ops complete in one cycle into a registered
//            result; with PIPE_EXE_MUL_EN defined, op 11 runs a WIDTH-step
//            shift-add multiply through an IDLE/MUL state machine.
// Macro    : PIPE_EXE_MUL_EN - builds the iterative multiplier (op 11).
//            Undefined: op 11 is a one-cycle op that yields 0.
// Ports    : clk, clrn (async active-low reset), eflush (sync flush)
//            in_valid/in_ready   - operation handshake
//            ealuc, eshift, ealuimm, eqa, eqb, eimm, esa - op and operands
//            out_valid/out_ready - result handshake
//            result, ezero       - registered result and zero flag
// Revision : 1.0 - initial release
// ============================================================================
module pipe_exe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               eflush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ealuc,
    input  logic               eshift,
    input  logic               ealuimm,
    input  logic [WIDTH-1:0]   eqa,
    input  logic [WIDTH-1:0]   eqb,
    input  logic [WIDTH-1:0]   eimm,
    input  logic [SHAMT_W-1:0] esa,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               ezero
);

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_lui  = 4'd5;
    localparam logic [3:0] c_op_sll  = 4'd6;
    localparam logic [3:0] c_op_srl  = 4'd7;
    localparam logic [3:0] c_op_sra  = 4'd8;
    localparam logic [3:0] c_op_slt  = 4'd9;
    localparam logic [3:0] c_op_sltu = 4'd10;
    localparam logic [3:0] c_op_mul  = 4'd11;

    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_alu;
    logic               w_accept;
    logic               w_is_mul;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_ezero;

    assign w_opa    = eshift  ? {{(WIDTH-SHAMT_W){1'b0}}, esa} : eqa;
    assign w_opb    = ealuimm ? eimm : eqb;
    assign w_shamt  = w_opa[SHAMT_W-1:0];
    assign w_is_mul = (ealuc == c_op_mul);
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ezero     = r_ezero;

    // Single-cycle ALU. Op 11 falls into the default (0); when the multiplier
    // is built, op 11 bypasses this path entirely.
    always_comb begin
        w_alu = '0;
        case (ealuc)
            c_op_add:  w_alu = w_opa + w_opb;
            c_op_sub:  w_alu = w_opa - w_opb;
            c_op_and:  w_alu = w_opa & w_opb;
            c_op_or:   w_alu = w_opa | w_opb;
            c_op_xor:  w_alu = w_opa ^ w_opb;
            c_op_lui:  w_alu = w_opb << (WIDTH/2);
            c_op_sll:  w_alu = w_opb << w_shamt;
            c_op_srl:  w_alu = w_opb >> w_shamt;
            c_op_sra:  w_alu = $signed(w_opb) >>> w_shamt;
            c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_opa) < $signed(w_opb))};
            c_op_sltu: w_alu = {{(WIDTH-1){1'b0}}, (w_opa < w_opb)};
            default:   w_alu = '0;
        endcase
    end

`ifdef PIPE_EXE_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic             w_mul_done;

    assign in_ready = (r_state == S_IDLE) && !eflush && (!r_out_valid || out_ready);

    // The product is only delivered once the output register is free; the
    // FSM otherwise waits with the counter parked at 0.
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == '0) && (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_result    <= '0;
            r_ezero     <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (eflush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state  <= S_MUL;
                        r_cnt    <= CNT_W'(WIDTH);
                        r_mcand  <= w_opa;
                        r_mplier <= w_opb;
                        r_acc    <= '0;
                    end
                end
                S_MUL: begin
                    if (r_cnt != '0) begin
                        // One multiplier bit per cycle, LSB first.
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt - CNT_W'(1);
                    end else if (w_mul_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_accept && !w_is_mul) begin
                r_result    <= w_alu;
                r_ezero     <= (w_alu == '0);
                r_out_valid <= 1'b1;
            end else if (w_mul_done) begin
                r_result    <= r_acc;
                r_ezero     <= (r_acc == '0);
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`else
    assign in_ready = !eflush && (!r_out_valid || out_ready);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_result    <= '0;
            r_ezero     <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (eflush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_result    <= w_alu;
            r_ezero     <= (w_alu == '0);
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_exe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_exe
// Purpose  : Self-checking bench for pipe_exe (WIDTH=32). Directed steps plus
//            a randomized section compared against a behavioural model.
//            Multiplier checks are compiled when PIPE_EXE_MUL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_exe;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clk       = 1'b0;
    logic               clrn      = 1'b0;
    logic               eflush    = 1'b0;
    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic [3:0]         ealuc     = 4'd0;
    logic               eshift    = 1'b0;
    logic               ealuimm   = 1'b0;
    logic [WIDTH-1:0]   eqa       = '0;
    logic [WIDTH-1:0]   eqb       = '0;
    logic [WIDTH-1:0]   eimm      = '0;
    logic [SHAMT_W-1:0] esa       = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   result;
    logic               ezero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_exe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .eflush    (eflush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ealuc     (ealuc),
        .eshift    (eshift),
        .ealuimm   (ealuimm),
        .eqa       (eqa),
        .eqb       (eqb),
        .eimm      (eimm),
        .esa       (esa),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ezero     (ezero)
    );

    // Reference behaviour of each op, from the op-code table.
    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     sh;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = longint'(a[4:0]);
        p  = '0;
        case (op)
            4'd0:  p = 64'(a) + 64'(b);
            4'd1:  p = 64'(a) + 64'(~b) + 64'd1;
            4'd2:  p = 64'(a & b);
            4'd3:  p = 64'(a | b);
            4'd4:  p = 64'(a ^ b);
            4'd5:  p = 64'(b) * 64'd65536;
            4'd6:  p = 64'(b) << sh;
            4'd7:  p = 64'(b) >> sh;
            4'd8:  p = 64'(sb >>> sh);
            4'd9:  p = (sa < sb) ? 64'd1 : 64'd0;
            4'd10: p = (64'(a) < 64'(b)) ? 64'd1 : 64'd0;
`ifdef PIPE_EXE_MUL_EN
            4'd11: p = 64'(a) * 64'(b);
`endif
            default: p = '0;
        endcase
        return p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic sh, input logic [4:0] s, input logic ui,
                          input logic [31:0] imm);
        ealuc    = op;
        eqa      = a;
        eqb      = b;
        eshift   = sh;
        esa      = s;
        ealuimm  = ui;
        eimm     = imm;
        in_valid = 1'b1;
    endtask

    logic        mv;
    logic [31:0] mr;
    logic [3:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        exp_rdy;
    int          lat;

    initial begin
        out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_ezero", 64'(ezero), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        tick();
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Back-to-back add then sub
        set_op(4'd0, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 32'd0);
        #1 chk("b2b_rdy0", 64'(in_ready), 64'd1);
        tick();
        chk("b2b_valid0", 64'(out_valid), 64'd1);
        chk("b2b_res0", 64'(result), 64'd12);
        chk("b2b_zero0", 64'(ezero), 64'd0);
        set_op(4'd1, 32'd3, 32'd3, 1'b0, 5'd0, 1'b0, 32'd0);
        #1 chk("b2b_rdy1", 64'(in_ready), 64'd1);
        tick();
        chk("b2b_valid1", 64'(out_valid), 64'd1);
        chk("b2b_res1", 64'(result), 64'd0);
        chk("b2b_zero1", 64'(ezero), 64'd1);
        in_valid = 1'b0;
        tick();
        chk("b2b_drain", 64'(out_valid), 64'd0);

        // Shifts with eshift-selected amount
        set_op(4'd8, 32'hDEAD_BEEF, 32'h8000_0000, 1'b1, 5'd4, 1'b0, 32'd0);
        tick();
        chk("sra", 64'(result), 64'hF800_0000);
        set_op(4'd7, 32'hDEAD_BEEF, 32'h8000_0000, 1'b1, 5'd4, 1'b0, 32'd0);
        tick();
        chk("srl", 64'(result), 64'h0800_0000);
        in_valid = 1'b0;
        tick();
        mv = 1'b0;
        mr = '0;

        // Randomized ops with random handshakes
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
`ifdef PIPE_EXE_MUL_EN
            if (op == 4'd11) op = 4'd0;
`endif
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            set_op(op, ra, rb, 1'($urandom_range(0, 1)), 5'($urandom),
                   1'($urandom_range(0, 1)), $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = !mv || out_ready;
            chk("rnd_ready", 64'(in_ready), 64'(exp_rdy));
            if (in_valid && exp_rdy) begin
                mr = ref_op(op, eshift ? {27'd0, esa} : eqa, ealuimm ? eimm : eqb);
                mv = 1'b1;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            tick();
            chk("rnd_valid", 64'(out_valid), 64'(mv));
            if (mv) begin
                chk("rnd_result", 64'(result), 64'(mr));
                chk("rnd_ezero", 64'(ezero), 64'(mr == 32'd0));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // Backpressure: result must hold while operands keep changing
        out_ready = 1'b0;
        set_op(4'd0, 32'd100, 32'd23, 1'b0, 5'd0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_op(4'd4, $urandom, $urandom, 1'b0, 5'd0, 1'b0, 32'd0);
            #1 chk("bp_ready", 64'(in_ready), 64'd0);
            tick();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_result", 64'(result), 64'd123);
        end
        out_ready = 1'b1;
        set_op(4'd2, 32'h0000_00FF, 32'h0000_000F, 1'b0, 5'd0, 1'b0, 32'd0);
        #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_result", 64'(result), 64'h0F);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Flush drops the held result and the op offered alongside it
        out_ready = 1'b0;
        set_op(4'd0, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 32'd0);
        tick();
        chk("fl_pre_valid", 64'(out_valid), 64'd1);
        eflush = 1'b1;
        set_op(4'd0, 32'd4, 32'd4, 1'b0, 5'd0, 1'b0, 32'd0);
        #1 chk("fl_ready", 64'(in_ready), 64'd0);
        tick();
        eflush   = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        #1 chk("fl_ready_after", 64'(in_ready), 64'd1);
        tick();
        chk("fl_no_result", 64'(out_valid), 64'd0);
        out_ready = 1'b1;

`ifdef PIPE_EXE_MUL_EN
        // Multiply latency and product
        set_op(4'd11, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 5'd0, 1'b0, 32'd0);
        #1 chk("mul_accept_ready", 64'(in_ready), 64'd1);
        tick();
        ealuc = 4'd0;
        lat   = 0;
        repeat (100) begin
            if (!out_valid) begin
                chk("mul_busy_ready", 64'(in_ready), 64'd0);
                tick();
                lat++;
            end
        end
        in_valid = 1'b0;
        chk("mul_latency", 64'(lat), 64'd33);
        chk("mul_result", 64'(result), 64'hFFFF_FFFF);
        chk("mul_ezero", 64'(ezero), 64'd0);
        tick();
        chk("mul_drain", 64'(out_valid), 64'd0);

        // Flush ten cycles into a multiply
        set_op(4'd11, $urandom, $urandom, 1'b0, 5'd0, 1'b0, 32'd0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        eflush = 1'b1;
        set_op(4'd0, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 32'd0);
        #1 chk("mfl_ready", 64'(in_ready), 64'd0);
        tick();
        eflush   = 1'b0;
        in_valid = 1'b0;
        chk("mfl_valid", 64'(out_valid), 64'd0);
        #1 chk("mfl_idle", 64'(in_ready), 64'd1);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("mfl_quiet", 64'(out_valid), 64'd0);
        end

        // Reset during a multiply
        set_op(4'd11, 32'd3, 32'd5, 1'b0, 5'd0, 1'b0, 32'd0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2 clrn = 1'b0;
        #1 chk("mrst_valid", 64'(out_valid), 64'd0);
        tick();
        clrn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("mrst_quiet", 64'(out_valid), 64'd0);
        end
`else
        // Op 11 without the multiplier: one cycle, yields 0
        set_op(4'd11, 32'd7, 32'd9, 1'b0, 5'd0, 1'b0, 32'd0);
        tick();
        chk("op11_valid", 64'(out_valid), 64'd1);
        chk("op11_result", 64'(result), 64'd0);
        chk("op11_ezero", 64'(ezero), 64'd1);
        in_valid = 1'b0;
        tick();
`endif

        // Asynchronous reset mid-stream with a held result
        out_ready = 1'b0;
        set_op(4'd0, 32'd9, 32'd9, 1'b0, 5'd0, 1'b0, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("ars_pre_result", 64'(result), 64'd18);
        #2 clrn = 1'b0;
        #1;
        chk("ars_result", 64'(result), 64'd0);
        chk("ars_ezero", 64'(ezero), 64'd1);
        chk("ars_valid", 64'(out_valid), 64'd0);
        tick();
        clrn = 1'b1;
        #1 chk("ars_ready", 64'(in_ready), 64'd1);
        tick();
        chk("ars_post_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
